fft2d_sched: RTL and testbench
==============================

# fft2d_sched

Parametrised pass scheduler for the multi-lane 2D FFT datapath. It sequences load, row pass, optional column pass and unload over a two-bank sample buffer. It generates per-lane read/write addresses, with a transposed order for the column pass, and drives the 1D FFT core's start/valid. It replaces the fixed 32-point, 4-lane stage sequencer, adding configurable size and lane count, a 1D/2D mode, a load/unload handshake with backpressure, and abort.

## Interface
- `LOG2_ROWS`, default 5: log2 of row count R.
- `LOG2_COLS`, default 5: log2 of column count C.
- `LOG2_LANES`, default 2: log2 of lanes per beat P. Must satisfy `LOG2_LANES <= min(LOG2_ROWS, LOG2_COLS)`.
- Derived `AW = LOG2_ROWS + LOG2_COLS`: per-lane sample-index width.
- One clock; reset is asynchronous and active-low.
- `clk_i`: in, 1. Clock.
- `rst_ni`: in, 1. Asynchronous reset, active low.
- `start_i`: in, 1. Start a transform. Honoured only in IDLE.
- `mode_2d_i`: in, 1. 1 = row + column pass; 0 = row pass only. Sampled with `start_i`.
- `abort_i`: in, 1. Synchronous abort to IDLE.
- `in_vld_i`: in, 1. Input beat valid.
- `in_rdy_o`: out, 1. Ready to accept an input beat.
- `out_rdy_i`: in, 1. Downstream can take a beat one cycle later.
- `out_vld_o`: out, 1. SRAM read data is a valid output beat.
- `core_vld_i`: in, 1. FFT core result beat valid.
- `core_start_o`: out, 1. First beat of a row/column at the core input.
- `core_vld_o`: out, 1. Core input beat valid.
- `wen_o`: out, 1. Buffer write enable, all lanes.
- `ren_o`: out, 1. Buffer read enable, all lanes.
- `bank_wr_o`, `bank_rd_o`: out, 1 each. Bank selects.
- `addr_wr_o`: out, P×AW. Per-lane write sample index.
- `addr_rd_o`: out, P×AW. Per-lane read sample index.
- `busy_o`: out, 1. State is not IDLE.
- `done_o`: out, 1. One-cycle completion pulse.

## Operation
- States: IDLE, LOAD, ROW, COL, UNLOAD.
- Reset: IDLE. All outputs 0, all counters 0.
- Transitions:
  - IDLE→LOAD on `start_i`; `mode_2d_i` is latched.
  - LOAD→ROW after R·C/P accepted beats.
  - ROW→COL (2D) or ROW→UNLOAD (1D) after the last ROW write.
  - COL→UNLOAD after the last COL write.
  - UNLOAD→IDLE after the last output beat.
- `abort_i` from any state returns to IDLE next cycle with counters cleared; no `done_o` pulse. `abort_i` beats `start_i` when both are high.
- Address maps: line `l`, beat `b`, lane `k`.
  - Row-major (LOAD, ROW, UNLOAD after 1D): index = l·C + b·P + k.
  - Transposed (COL, UNLOAD after 2D): index = (b·P + k)·C + l.
  - ROW: C/P beats per line, R lines. COL: R/P beats per line, C lines.
- LOAD: `in_rdy_o`=1. `wen_o` = `in_vld_i`. Bank 0, row-major. The write counter advances on each handshake.
- ROW: read bank 0, write bank 1. COL: read bank 1, write bank 0.
- ROW/COL read side:
  - `ren_o`=1 every cycle until all R·C/P beats are issued, then 0.
  - The read counter walks beats, then lines.
- ROW/COL write side:
  - `wen_o` = `core_vld_i`, using the same address map as the pass.
  - The write counter advances only on `core_vld_i`. Read and write sides are independent, so core latency is arbitrary.
- UNLOAD: read the last-written bank (bank 1 after 1D, bank 0 after 2D).
  - `ren_o` = `out_rdy_i` while beats remain.
- `core_vld_i` outside ROW/COL is ignored, with no write.
- Counters wrap to 0 at each pass boundary.

## Timing
- Buffer read latency is 1 cycle.
- `core_vld_o` and `out_vld_o` are `ren_o` registered one cycle, qualified by the state at issue.
- `core_start_o` = `core_vld_o` ∧ (the registered beat index was 0).
- `addr_*`, `bank_*`, `wen_o` and `ren_o` are combinational from state, counters and handshakes. `wen_o` is asserted in the same cycle as its data.
- The first ROW `ren_o` is in the cycle after the last LOAD handshake.
- A transition out of ROW/COL occurs the cycle after the final `core_vld_i` write.
- `done_o` and the return to IDLE occur the cycle after the last UNLOAD `ren_o`, i.e. coincident with the last `out_vld_o`.
- `busy_o` falls in that same cycle.
- `start_i` is accepted in the same cycle that `done_o` is high (IDLE next).

## Test plan
- R=C=8, P=2, 1D mode:
  - Load 32 beats with `in_vld_i` toggling every other cycle → 32 writes, lane0 addresses 0,2,4…62.
  - Echo `core_vld_i` with 3-cycle delay → 32 ROW writes to bank 1.
  - UNLOAD reads bank 1; `done_o` on the 32nd `out_vld_o`.
- Same config, 2D mode:
  - COL beat 0 of column 3 reads indices 3 and 11.
  - Beat 1 reads 19 and 27.
  - `core_start_o` fires 8 times in each pass.
  - UNLOAD is from bank 0 in transposed order.
- `out_rdy_i` low 5 cycles mid-UNLOAD → no `ren_o` or `out_vld_o` gaps beyond the stall; no beat lost or duplicated (32 beats total).
- Core latency 0 vs 20 cycles → identical write address sequences; the state advances only after the 32nd `core_vld_i`.
- `abort_i` in COL at write 10 → IDLE next cycle, `busy_o`=0, no `done_o`; a new `start_i` begins with LOAD address 0.
- Reset asserted mid-ROW → all outputs 0 immediately; IDLE after release.
- Spurious `core_vld_i` in IDLE → no write.

Source files
------------

// File: rtl/fft2d_sched_if.sv
// Handshake and buffer-address bundle between the 2D FFT pass scheduler and its surroundings.
// master: controller/datapath side; slave: the scheduler itself.
interface fft2d_sched_if #(
   parameter int LOG2_ROWS  = 5,
   parameter int LOG2_COLS  = 5,
   parameter int LOG2_LANES = 2
);
   localparam int AW = LOG2_ROWS + LOG2_COLS;
   localparam int P  = 1 << LOG2_LANES;

   logic start_i;
   logic mode_2d_i;
   logic abort_i;
   logic in_vld_i;
   logic in_rdy_o;
   logic out_rdy_i;
   logic out_vld_o;
   logic core_vld_i;
   logic core_start_o;
   logic core_vld_o;
   logic wen_o;
   logic ren_o;
   logic bank_wr_o;
   logic bank_rd_o;
   logic [P-1:0][AW-1:0] addr_wr_o;
   logic [P-1:0][AW-1:0] addr_rd_o;
   logic busy_o;
   logic done_o;

   modport master (
      output start_i, mode_2d_i, abort_i, in_vld_i, out_rdy_i, core_vld_i,
      input  in_rdy_o, out_vld_o, core_start_o, core_vld_o, wen_o, ren_o,
             bank_wr_o, bank_rd_o, addr_wr_o, addr_rd_o, busy_o, done_o
   );

   modport slave (
      input  start_i, mode_2d_i, abort_i, in_vld_i, out_rdy_i, core_vld_i,
      output in_rdy_o, out_vld_o, core_start_o, core_vld_o, wen_o, ren_o,
             bank_wr_o, bank_rd_o, addr_wr_o, addr_rd_o, busy_o, done_o
   );
endinterface

// File: rtl/fft2d_sched.sv
// Load / row / column / unload pass sequencer over a two-bank buffer; addresses, wen, ren are combinational,
// core_vld/out_vld follow ren by one cycle (buffer read latency); input never stalls, unload stalls on out_rdy_i.
module fft2d_sched #(
   parameter int LOG2_ROWS  = 5,
   parameter int LOG2_COLS  = 5,
   parameter int LOG2_LANES = 2
) (
   input logic         clk_i,
   input logic         rst_ni,
   fft2d_sched_if.slave bus
);
   localparam int AW  = LOG2_ROWS + LOG2_COLS;
   localparam int P   = 1 << LOG2_LANES;
   localparam int NB  = AW - LOG2_LANES;
   localparam int RSH = LOG2_ROWS - LOG2_LANES;
   localparam int CSH = LOG2_COLS - LOG2_LANES;

   localparam logic [NB-1:0] LAST  = '1;
   localparam logic [NB-1:0] RMASK = NB'((1 << RSH) - 1);
   localparam logic [NB-1:0] CMASK = NB'((1 << CSH) - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_ROW    = 3'd2;
   localparam logic [2:0] S_COL    = 3'd3;
   localparam logic [2:0] S_UNLOAD = 3'd4;

   logic [2:0]    state;
   logic          mode_q;
   logic [NB-1:0] wr_cnt;
   logic [NB-1:0] rd_cnt;
   logic          rd_all;
   logic          core_vld_q;
   logic          out_vld_q;
   logic          beat0_q;
   logic          done_q;

   logic          in_rdy;
   logic          wen;
   logic          ren;
   logic          bank_wr;
   logic          bank_rd;
   logic          rd_beat0;
   logic [P-1:0][AW-1:0] addr_wr;
   logic [P-1:0][AW-1:0] addr_rd;

   // Linear beat counter -> sample index. Row-major is just {cnt, lane}.
   function automatic logic [AW-1:0] row_idx(input logic [NB-1:0] cnt, input int k);
      return (AW'(cnt) << LOG2_LANES) | AW'(k);
   endfunction

   // Transposed: line l = cnt / (R/P), beat b = cnt % (R/P), index = (b*P + k)*C + l.
   function automatic logic [AW-1:0] col_idx(input logic [NB-1:0] cnt, input int k);
      logic [AW-1:0] b;
      logic [AW-1:0] l;
      b = AW'(cnt & RMASK);
      l = AW'(cnt >> RSH);
      return (((b << LOG2_LANES) | AW'(k)) << LOG2_COLS) | l;
   endfunction

   always_comb begin
      in_rdy  = 1'b0;
      wen     = 1'b0;
      ren     = 1'b0;
      bank_wr = 1'b0;
      bank_rd = 1'b0;
      addr_wr = '0;
      addr_rd = '0;
      case (state)
         S_LOAD: begin
            in_rdy = 1'b1;
            wen    = bus.in_vld_i;
            for (int k = 0; k < P; k++) addr_wr[k] = row_idx(wr_cnt, k);
         end
         S_ROW: begin
            ren     = !rd_all;
            wen     = bus.core_vld_i;
            bank_wr = 1'b1;
            for (int k = 0; k < P; k++) begin
               addr_rd[k] = row_idx(rd_cnt, k);
               addr_wr[k] = row_idx(wr_cnt, k);
            end
         end
         S_COL: begin
            ren     = !rd_all;
            wen     = bus.core_vld_i;
            bank_rd = 1'b1;
            for (int k = 0; k < P; k++) begin
               addr_rd[k] = col_idx(rd_cnt, k);
               addr_wr[k] = col_idx(wr_cnt, k);
            end
         end
         S_UNLOAD: begin
            ren     = bus.out_rdy_i;
            bank_rd = !mode_q;
            for (int k = 0; k < P; k++)
               addr_rd[k] = mode_q ? col_idx(rd_cnt, k) : row_idx(rd_cnt, k);
         end
         default: ;
      endcase
   end

   always_comb begin
      rd_beat0 = 1'b0;
      if (state == S_ROW) rd_beat0 = (rd_cnt & CMASK) == '0;
      else if (state == S_COL) rd_beat0 = (rd_cnt & RMASK) == '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= S_IDLE;
         mode_q     <= 1'b0;
         wr_cnt     <= '0;
         rd_cnt     <= '0;
         rd_all     <= 1'b0;
         core_vld_q <= 1'b0;
         out_vld_q  <= 1'b0;
         beat0_q    <= 1'b0;
         done_q     <= 1'b0;
      end else if (bus.abort_i) begin
         state      <= S_IDLE;
         wr_cnt     <= '0;
         rd_cnt     <= '0;
         rd_all     <= 1'b0;
         core_vld_q <= 1'b0;
         out_vld_q  <= 1'b0;
         beat0_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         core_vld_q <= ren && (state == S_ROW || state == S_COL);
         out_vld_q  <= ren && (state == S_UNLOAD);
         beat0_q    <= rd_beat0;
         done_q     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start_i) begin
                  state  <= S_LOAD;
                  mode_q <= bus.mode_2d_i;
               end
            end
            S_LOAD: begin
               if (wen) begin
                  wr_cnt <= wr_cnt + 1'b1;
                  if (wr_cnt == LAST) state <= S_ROW;
               end
            end
            S_ROW, S_COL: begin
               if (ren) begin
                  rd_cnt <= rd_cnt + 1'b1;
                  if (rd_cnt == LAST) rd_all <= 1'b1;
               end
               // The pass ends on the last core write, not the last read: core latency is unbounded.
               if (wen) begin
                  wr_cnt <= wr_cnt + 1'b1;
                  if (wr_cnt == LAST) begin
                     state  <= (state == S_ROW && mode_q) ? S_COL : S_UNLOAD;
                     rd_cnt <= '0;
                     rd_all <= 1'b0;
                  end
               end
            end
            S_UNLOAD: begin
               if (ren) begin
                  rd_cnt <= rd_cnt + 1'b1;
                  if (rd_cnt == LAST) begin
                     state  <= S_IDLE;
                     done_q <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_rdy_o     = in_rdy;
   assign bus.wen_o        = wen;
   assign bus.ren_o        = ren;
   assign bus.bank_wr_o    = bank_wr;
   assign bus.bank_rd_o    = bank_rd;
   assign bus.addr_wr_o    = addr_wr;
   assign bus.addr_rd_o    = addr_rd;
   assign bus.core_vld_o   = core_vld_q;
   assign bus.out_vld_o    = out_vld_q;
   assign bus.core_start_o = core_vld_q && beat0_q;
   assign bus.busy_o       = state != S_IDLE;
   assign bus.done_o       = done_q;
endmodule

// File: tb/tb_fft2d_sched.sv
// Directed bench for fft2d_sched at R=C=8, P=2: 1D, 2D, stall, core latency, abort, reset and spurious core beats.
module tb_fft2d_sched;
   typedef struct {
      int cyc;
      int bank;
      int a0;
      int a1;
   } acc_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft2d_sched_if #(.LOG2_ROWS(3), .LOG2_COLS(3), .LOG2_LANES(1)) bus ();
   fft2d_sched #(.LOG2_ROWS(3), .LOG2_COLS(3), .LOG2_LANES(1)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   vhist[64];
   int   dly = 3;
   bit   force_core = 0;
   bit   load_toggle = 0;
   bit   nxt_start = 0;
   bit   cur_mode = 0;
   int   stall_at = 0;
   int   stall_left = 0;
   int   abort_at = 0;
   int   abort_cyc = 0;
   int   out_cnt, start_cnt, done_seen, done_out_cnt, done_cyc, done_busy, first_out, last_out;
   acc_t wr_log[$];
   acc_t rd_log[$];

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int row_e(input int bank, input int cnt);
      return bank * 65536 + (cnt * 2) * 256 + cnt * 2 + 1;
   endfunction

   function automatic int col_e(input int bank, input int cnt);
      int base;
      base = ((cnt % 4) * 2) * 8 + cnt / 4;
      return bank * 65536 + base * 256 + base + 8;
   endfunction

   function automatic int wr_pk(input int i);
      if (i >= wr_log.size()) return -1;
      return wr_log[i].bank * 65536 + wr_log[i].a0 * 256 + wr_log[i].a1;
   endfunction

   function automatic int rd_pk(input int i);
      if (i >= rd_log.size()) return -1;
      return rd_log[i].bank * 65536 + rd_log[i].a0 * 256 + rd_log[i].a1;
   endfunction

   function automatic int wr_cyc(input int i);
      return (i < wr_log.size()) ? wr_log[i].cyc : -1;
   endfunction

   function automatic int rd_cyc(input int i);
      return (i < rd_log.size()) ? rd_log[i].cyc : -1;
   endfunction

   task automatic clear_logs();
      wr_log.delete();
      rd_log.delete();
      out_cnt = 0; start_cnt = 0; done_seen = 0; done_out_cnt = -1;
      done_cyc = -1; done_busy = -1; first_out = -1; last_out = -1;
      for (int i = 0; i < 64; i++) vhist[i] = 1'b0;
   endtask

   // Drive one cycle's inputs at the falling edge, then sample outputs 1 time unit later.
   task automatic clk_step();
      acc_t e;
      @(negedge clk);
      cyc++;
      vhist[cyc & 63] = bus.core_vld_o;
      bus.core_vld_i = force_core | vhist[(cyc - dly) & 63];
      bus.in_vld_i   = load_toggle ? cyc[0] : 1'b1;
      bus.out_rdy_i  = (stall_left > 0) ? 1'b0 : 1'b1;
      bus.mode_2d_i  = cur_mode;
      bus.start_i    = nxt_start;
      nxt_start      = 0;
      bus.abort_i    = (abort_at > 0 && wr_log.size() == abort_at - 1 && bus.core_vld_i);
      if (bus.abort_i) begin
         abort_cyc = cyc;
         abort_at  = 0;
      end
      #1;
      if (bus.wen_o) begin
         e.cyc = cyc; e.bank = int'(bus.bank_wr_o);
         e.a0 = int'(bus.addr_wr_o[0]); e.a1 = int'(bus.addr_wr_o[1]);
         wr_log.push_back(e);
      end
      if (bus.ren_o) begin
         e.cyc = cyc; e.bank = int'(bus.bank_rd_o);
         e.a0 = int'(bus.addr_rd_o[0]); e.a1 = int'(bus.addr_rd_o[1]);
         rd_log.push_back(e);
      end
      if (bus.out_vld_o) begin
         out_cnt++;
         if (first_out < 0) first_out = cyc;
         last_out = cyc;
      end
      if (bus.core_start_o) start_cnt++;
      if (bus.done_o) begin
         done_seen++; done_out_cnt = out_cnt; done_cyc = cyc; done_busy = int'(bus.busy_o);
      end
      if (stall_left > 0) stall_left--;
      else if (stall_at > 0 && out_cnt == stall_at) begin
         stall_left = 5;
         stall_at   = 0;
      end
   endtask

   task automatic run_until_done(input string tag, input int max_cyc);
      for (int i = 0; i < max_cyc && done_seen == 0; i++) clk_step();
      check({tag, "_done_seen"}, done_seen, 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, int'(bus.busy_o), 0);
      check({tag, "_done"}, int'(bus.done_o), 0);
      check({tag, "_ren"}, int'(bus.ren_o), 0);
      check({tag, "_wen"}, int'(bus.wen_o), 0);
      check({tag, "_in_rdy"}, int'(bus.in_rdy_o), 0);
      check({tag, "_core_vld"}, int'(bus.core_vld_o), 0);
      check({tag, "_out_vld"}, int'(bus.out_vld_o), 0);
      check({tag, "_addr"}, int'({bus.addr_wr_o, bus.addr_rd_o}), 0);
   endtask

   initial begin
      bus.start_i = 0; bus.mode_2d_i = 0; bus.abort_i = 0; bus.in_vld_i = 0;
      bus.out_rdy_i = 1; bus.core_vld_i = 0;
      clear_logs();
      repeat (3) @(negedge clk);
      #1 check_idle_outputs("reset");
      #1 rst_n = 1'b1;

      // 1D, toggling input valid, core echo delay 3
      cur_mode = 0; dly = 3; load_toggle = 1; clear_logs(); nxt_start = 1;
      run_until_done("d1", 2000);
      check("d1_wr_count", wr_log.size(), 64);
      check("d1_rd_count", rd_log.size(), 64);
      for (int i = 0; i < 32; i++) begin
         check($sformatf("d1_load_wr%0d", i), wr_pk(i), row_e(0, i));
         check($sformatf("d1_row_wr%0d", i), wr_pk(32 + i), row_e(1, i));
         check($sformatf("d1_row_rd%0d", i), rd_pk(i), row_e(0, i));
         check($sformatf("d1_unl_rd%0d", i), rd_pk(32 + i), row_e(1, i));
      end
      check("d1_load_gap", wr_cyc(1) - wr_cyc(0), 2);
      check("d1_row_first_ren", rd_cyc(0), wr_cyc(31) + 1);
      check("d1_core_lat", wr_cyc(32), rd_cyc(0) + 4);
      check("d1_starts", start_cnt, 8);
      check("d1_out_cnt", out_cnt, 32);
      check("d1_done_on_last", done_out_cnt, 32);
      check("d1_done_cyc", done_cyc, last_out);
      check("d1_done_busy", done_busy, 0);

      // 2D with a 5-cycle downstream stall during unload
      cur_mode = 1; dly = 3; load_toggle = 0; clear_logs(); stall_at = 10; nxt_start = 1;
      run_until_done("d2", 3000);
      check("d2_wr_count", wr_log.size(), 96);
      check("d2_rd_count", rd_log.size(), 96);
      check("d2_col3_beat0", rd_pk(44), 65536 + 3 * 256 + 11);
      check("d2_col3_beat1", rd_pk(45), 65536 + 19 * 256 + 27);
      for (int i = 0; i < 32; i++) begin
         check($sformatf("d2_row_wr%0d", i), wr_pk(32 + i), row_e(1, i));
         check($sformatf("d2_col_wr%0d", i), wr_pk(64 + i), col_e(0, i));
         check($sformatf("d2_col_rd%0d", i), rd_pk(32 + i), col_e(1, i));
         check($sformatf("d2_unl_rd%0d", i), rd_pk(64 + i), col_e(0, i));
      end
      check("d2_col_first_ren", rd_cyc(32), wr_cyc(63) + 1);
      check("d2_starts", start_cnt, 16);
      check("d2_out_cnt", out_cnt, 32);
      check("d2_unl_ren_span", rd_cyc(95) - rd_cyc(64), 36);
      check("d2_out_span", last_out - first_out, 36);
      check("d2_done_on_last", done_out_cnt, 32);
      check("d2_done_cyc", done_cyc, last_out);

      // Core latency 0 and 20: same write sequence, unload only after the 32nd core beat
      for (int pass = 0; pass < 2; pass++) begin
         cur_mode = 0; dly = (pass == 0) ? 0 : 20; clear_logs(); nxt_start = 1;
         run_until_done($sformatf("lat%0d", dly), 2000);
         for (int i = 0; i < 32; i++)
            check($sformatf("lat%0d_row_wr%0d", dly, i), wr_pk(32 + i), row_e(1, i));
         check($sformatf("lat%0d_core_lat", dly), wr_cyc(32), rd_cyc(0) + 1 + dly);
         check($sformatf("lat%0d_unl_after", dly), rd_cyc(32), wr_cyc(63) + 1);
         check($sformatf("lat%0d_out_cnt", dly), out_cnt, 32);
      end

      // Abort on the 10th column write, then spurious core beats in IDLE
      cur_mode = 1; dly = 3; clear_logs(); abort_at = 74; abort_cyc = 0; nxt_start = 1;
      for (int i = 0; i < 2000 && abort_cyc == 0; i++) clk_step();
      check("abort_fired", int'(abort_cyc > 0), 1);
      clk_step();
      check_idle_outputs("abort_next");
      force_core = 1;
      repeat (10) clk_step();
      force_core = 0;
      check("abort_no_done", done_seen, 0);
      check("spurious_no_wr", wr_log.size(), 74);
      cur_mode = 0; clear_logs(); nxt_start = 1;
      run_until_done("post_abort", 2000);
      check("post_abort_addr0", wr_pk(0), row_e(0, 0));
      check("post_abort_out", out_cnt, 32);

      // Asynchronous reset in the middle of the row pass
      cur_mode = 0; dly = 3; clear_logs(); nxt_start = 1;
      for (int i = 0; i < 500 && wr_log.size() < 40; i++) clk_step();
      check("rst_reached_row", int'(wr_log.size() >= 40), 1);
      #1 rst_n = 1'b0;
      #1 check_idle_outputs("rst_mid");
      clk_step();
      clk_step();
      #2 rst_n = 1'b1;
      clk_step();
      check("rst_release_busy", int'(bus.busy_o), 0);
      clear_logs(); nxt_start = 1;
      run_until_done("post_rst", 2000);
      check("post_rst_addr0", wr_pk(0), row_e(0, 0));
      check("post_rst_wr", wr_log.size(), 64);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
